// File: rtl/ecc_seq_pkg.sv
// Shared definitions for the ECC point-multiplication sequencer:
// micro-op encoding, register map, microcode ROM and FSM states.
package ecc_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_INV = 2'd3;

  localparam logic [2:0] R_QX   = 3'd0;
  localparam logic [2:0] R_QY   = 3'd1;
  localparam logic [2:0] R_PX   = 3'd2;
  localparam logic [2:0] R_PY   = 3'd3;
  localparam logic [2:0] R_A    = 3'd4;
  localparam logic [2:0] R_T0   = 3'd5;
  localparam logic [2:0] R_T1   = 3'd6;
  localparam logic [2:0] R_ZERO = 3'd7;

  localparam logic [4:0] DBL_BASE = 5'd0;
  localparam logic [4:0] DBL_LEN  = 5'd14;
  localparam logic [4:0] ADD_BASE = 5'd14;
  localparam logic [4:0] ADD_LEN  = 5'd11;
  localparam logic [4:0] DBL_LAST = DBL_BASE + DBL_LEN - 5'd1;
  localparam logic [4:0] ADD_LAST = ADD_BASE + ADD_LEN - 5'd1;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] dst;
    logic [2:0] src_a;
    logic [2:0] src_b;
  } uinst_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BIT,
    S_CHKD,
    S_SELADD,
    S_CHKA,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  function automatic uinst_t ui(
    input logic [1:0] op,
    input logic [2:0] d,
    input logic [2:0] a,
    input logic [2:0] b
  );
    uinst_t u;
    u.op    = op;
    u.dst   = d;
    u.src_a = a;
    u.src_b = b;
    return u;
  endfunction

  // R5 carries lambda, R6 carries x3; R0 is scratch until the final move.
  function automatic uinst_t rom(input logic [4:0] pc);
    uinst_t u;
    case (pc)
      5'd0:    u = ui(OP_MUL, R_T0, R_QX, R_QX);
      5'd1:    u = ui(OP_ADD, R_T1, R_T0, R_T0);
      5'd2:    u = ui(OP_ADD, R_T0, R_T1, R_T0);
      5'd3:    u = ui(OP_ADD, R_T0, R_T0, R_A);
      5'd4:    u = ui(OP_ADD, R_T1, R_QY, R_QY);
      5'd5:    u = ui(OP_INV, R_T1, R_T1, R_ZERO);
      5'd6:    u = ui(OP_MUL, R_T0, R_T0, R_T1);
      5'd7:    u = ui(OP_MUL, R_T1, R_T0, R_T0);
      5'd8:    u = ui(OP_SUB, R_T1, R_T1, R_QX);
      5'd9:    u = ui(OP_SUB, R_T1, R_T1, R_QX);
      5'd10:   u = ui(OP_SUB, R_QX, R_QX, R_T1);
      5'd11:   u = ui(OP_MUL, R_QX, R_T0, R_QX);
      5'd12:   u = ui(OP_SUB, R_QY, R_QX, R_QY);
      5'd13:   u = ui(OP_ADD, R_QX, R_T1, R_ZERO);
      5'd14:   u = ui(OP_SUB, R_T0, R_PY, R_QY);
      5'd15:   u = ui(OP_SUB, R_T1, R_PX, R_QX);
      5'd16:   u = ui(OP_INV, R_T1, R_T1, R_ZERO);
      5'd17:   u = ui(OP_MUL, R_T0, R_T0, R_T1);
      5'd18:   u = ui(OP_MUL, R_T1, R_T0, R_T0);
      5'd19:   u = ui(OP_SUB, R_T1, R_T1, R_QX);
      5'd20:   u = ui(OP_SUB, R_T1, R_T1, R_PX);
      5'd21:   u = ui(OP_SUB, R_QX, R_QX, R_T1);
      5'd22:   u = ui(OP_MUL, R_QX, R_T0, R_QX);
      5'd23:   u = ui(OP_SUB, R_QY, R_QX, R_QY);
      5'd24:   u = ui(OP_ADD, R_QX, R_T1, R_ZERO);
      default: u = ui(OP_ADD, R_ZERO, R_ZERO, R_ZERO);
    endcase
    return u;
  endfunction

endpackage

// File: rtl/ecc_seq_regfile.sv
// Point register file: 8 x SIZE, two read ports, one micro-op write
// port, plus bulk load of the base point and Q <- P copy.
module ecc_seq_regfile
  import ecc_seq_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [SIZE-1:0] i_px,
  input  logic [SIZE-1:0] i_py,
  input  logic [SIZE-1:0] i_a,
  input  logic            i_copy_p,
  input  logic            i_we,
  input  logic [2:0]      i_waddr,
  input  logic [SIZE-1:0] i_wdata,
  input  logic [2:0]      i_raddr0,
  input  logic [2:0]      i_raddr1,
  output logic [SIZE-1:0] o_rdata0,
  output logic [SIZE-1:0] o_rdata1,
  output logic            o_qp_xeq,
  output logic            o_qp_yeq,
  output logic            o_qy_zero
);

  logic [SIZE-1:0] r_q [0:7];
  logic [SIZE-1:0] r_d [0:7];

  always_comb begin
    r_d = r_q;
    if (i_load) begin
      for (int i = 0; i < 8; i++) r_d[i] = '0;
      r_d[R_PX] = i_px;
      r_d[R_PY] = i_py;
      r_d[R_A]  = i_a;
    end else if (i_copy_p) begin
      r_d[R_QX] = r_q[R_PX];
      r_d[R_QY] = r_q[R_PY];
    end else if (i_we) begin
      r_d[i_waddr] = i_wdata;
    end
    r_d[R_ZERO] = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign o_rdata0  = r_q[i_raddr0];
  assign o_rdata1  = r_q[i_raddr1];
  assign o_qp_xeq  = (r_q[R_QX] == r_q[R_PX]);
  assign o_qp_yeq  = (r_q[R_QY] == r_q[R_PY]);
  assign o_qy_zero = (r_q[R_QY] == '0);

endmodule

// File: rtl/ecc_point_mult_sequencer.sv
// MSB-first double-and-add scheduler: computes Q = k*P by issuing
// DBL/ADD microcode one GFAU micro-op at a time.
module ecc_point_mult_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int KEY_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_k,
  input  logic [SIZE-1:0]  i_px,
  input  logic [SIZE-1:0]  i_py,
  input  logic [SIZE-1:0]  i_a,
  output logic             o_busy,
  output logic             o_done,
  output logic [SIZE-1:0]  o_qx,
  output logic [SIZE-1:0]  o_qy,
  output logic             o_inf,
  output logic             o_gfau_start,
  output logic [1:0]       o_gfau_op,
  output logic [SIZE-1:0]  o_gfau_in0,
  output logic [SIZE-1:0]  o_gfau_in1,
  input  logic             i_gfau_done,
  input  logic [SIZE-1:0]  i_gfau_result
);

  localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(KEY_W - 1);

  state_e           state_q, state_d;
  logic [4:0]       pc_q, pc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic             inf_q, inf_d;
  logic             dbl_add_q, dbl_add_d;
  logic [SIZE-1:0]  qx_q, qx_d;
  logic [SIZE-1:0]  qy_q, qy_d;
  logic             qinf_q, qinf_d;

  uinst_t          ins;
  logic            exec;
  logic            load, copy_p, we;
  logic [SIZE-1:0] rd0, rd1;
  logic            xeq, yeq, qy_zero;

  assign ins  = rom(pc_q);
  assign exec = (state_q == S_ISSUE) || (state_q == S_WAIT);

  ecc_seq_regfile #(.SIZE(SIZE)) u_rf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (load),
    .i_px      (i_px),
    .i_py      (i_py),
    .i_a       (i_a),
    .i_copy_p  (copy_p),
    .i_we      (we),
    .i_waddr   (ins.dst),
    .i_wdata   (i_gfau_result),
    .i_raddr0  (exec ? ins.src_a : R_QX),
    .i_raddr1  (exec ? ins.src_b : R_QY),
    .o_rdata0  (rd0),
    .o_rdata1  (rd1),
    .o_qp_xeq  (xeq),
    .o_qp_yeq  (yeq),
    .o_qy_zero (qy_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    k_d       = k_q;
    inf_d     = inf_q;
    dbl_add_d = dbl_add_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    qinf_d    = qinf_q;
    load      = 1'b0;
    copy_p    = 1'b0;
    we        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          load      = 1'b1;
          k_d       = i_k;
          inf_d     = 1'b1;
          dbl_add_d = 1'b0;
          idx_d     = IDX_TOP;
          state_d   = S_BIT;
        end
      end
      S_BIT: begin
        state_d = inf_q ? S_SELADD : S_CHKD;
      end
      // A doubling that stands in for Q+P (Q == P) resumes at NEXT.
      S_CHKD: begin
        if (qy_zero) begin
          inf_d     = 1'b1;
          dbl_add_d = 1'b0;
          state_d   = dbl_add_q ? S_NEXT : S_SELADD;
        end else begin
          pc_d    = DBL_BASE;
          state_d = S_ISSUE;
        end
      end
      S_SELADD: begin
        if (!k_q[idx_q]) begin
          state_d = S_NEXT;
        end else if (inf_q) begin
          copy_p  = 1'b1;
          inf_d   = 1'b0;
          state_d = S_NEXT;
        end else begin
          state_d = S_CHKA;
        end
      end
      S_CHKA: begin
        if (xeq && yeq) begin
          dbl_add_d = 1'b1;
          state_d   = S_CHKD;
        end else if (xeq) begin
          inf_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          pc_d    = ADD_BASE;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_gfau_done) begin
          we = 1'b1;
          if (pc_q == DBL_LAST) begin
            dbl_add_d = 1'b0;
            state_d   = dbl_add_q ? S_NEXT : S_SELADD;
          end else if (pc_q == ADD_LAST) begin
            state_d = S_NEXT;
          end else begin
            pc_d    = pc_q + 5'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          qx_d    = inf_q ? '0 : rd0;
          qy_d    = inf_q ? '0 : rd1;
          qinf_d  = inf_q;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = S_BIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      idx_q     <= '0;
      k_q       <= '0;
      inf_q     <= 1'b0;
      dbl_add_q <= 1'b0;
      qx_q      <= '0;
      qy_q      <= '0;
      qinf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      inf_q     <= inf_d;
      dbl_add_q <= dbl_add_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      qinf_q    <= qinf_d;
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_qx         = qx_q;
  assign o_qy         = qy_q;
  assign o_inf        = qinf_q;
  assign o_gfau_start = (state_q == S_ISSUE);
  assign o_gfau_op    = exec ? ins.op : OP_ADD;
  assign o_gfau_in0   = exec ? rd0 : '0;
  assign o_gfau_in1   = exec ? rd1 : '0;

endmodule

// File: tb/tb_ecc_point_mult_sequencer.sv
// Bench: mod-17 GFAU with random latency, affine curve reference model
// on y^2 = x^3 + 2x + 2 (mod 17), P = (5,1).
module tb_ecc_point_mult_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_k = '0;
  logic [31:0] i_px = 32'd5;
  logic [31:0] i_py = 32'd1;
  logic [31:0] i_a = 32'd2;
  logic        o_busy, o_done, o_inf, o_gfau_start;
  logic [31:0] o_qx, o_qy, o_gfau_in0, o_gfau_in1;
  logic [1:0]  o_gfau_op;
  logic        i_gfau_done = 1'b0;
  logic [31:0] i_gfau_result = '0;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int done_cnt = 0;
  int exp_qx = 0;
  int exp_qy = 0;
  bit exp_inf = 1'b0;
  bit inject_stale = 1'b0;
  int pend_cnt = 0;
  int pend_res = 0;

  ecc_point_mult_sequencer #(.SIZE(32), .KEY_W(32)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_k           (i_k),
    .i_px          (i_px),
    .i_py          (i_py),
    .i_a           (i_a),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_qx          (o_qx),
    .o_qy          (o_qy),
    .o_inf         (o_inf),
    .o_gfau_start  (o_gfau_start),
    .o_gfau_op     (o_gfau_op),
    .o_gfau_in0    (o_gfau_in0),
    .o_gfau_in1    (o_gfau_in1),
    .i_gfau_done   (i_gfau_done),
    .i_gfau_result (i_gfau_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int md(input int v);
    return ((v % 17) + 17) % 17;
  endfunction

  function automatic int finv(input int a);
    int r = 1;
    repeat (15) r = md(r * a);
    return r;
  endfunction

  function automatic int gf(input logic [1:0] op, input int a, input int b);
    case (op)
      2'd0:    return md(a + b);
      2'd1:    return md(a - b);
      2'd2:    return md(a * b);
      default: return finv(md(a));
    endcase
  endfunction

  function automatic void ec_add(input int x1, input int y1, input bit i1,
                                 input int x2, input int y2, input bit i2,
                                 output int x3, output int y3, output bit i3);
    int lam;
    i3 = 1'b0;
    x3 = 0;
    y3 = 0;
    if (i1) begin
      x3 = x2; y3 = y2; i3 = i2;
    end else if (i2) begin
      x3 = x1; y3 = y1; i3 = i1;
    end else if (x1 == x2 && md(y1 + y2) == 0) begin
      i3 = 1'b1;
    end else begin
      if (x1 == x2) lam = md(md(3 * x1 * x1 + 2) * finv(md(2 * y1)));
      else          lam = md(md(y2 - y1) * finv(md(x2 - x1)));
      x3 = md(lam * lam - x1 - x2);
      y3 = md(lam * md(x1 - x3) - y1);
    end
  endfunction

  function automatic void ec_mul(input logic [31:0] k, output int x,
                                 output int y, output bit inf);
    int tx = 5, ty = 1;
    bit ti = 1'b0;
    x = 0; y = 0; inf = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (k[b]) ec_add(x, y, inf, tx, ty, ti, x, y, inf);
      ec_add(tx, ty, ti, tx, ty, ti, tx, ty, ti);
    end
  endfunction

  // GFAU stand-in: computes each micro-op, answers after 1-6 cycles.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_gfau_done = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          i_gfau_done   = 1'b1;
          i_gfau_result = pend_res;
        end
      end else if (inject_stale) begin
        inject_stale  = 1'b0;
        i_gfau_done   = 1'b1;
        i_gfau_result = 32'hdead;
      end
      if (o_gfau_start) begin
        starts++;
        pend_res = gf(o_gfau_op, int'(o_gfau_in0), int'(o_gfau_in1));
        pend_cnt = $urandom_range(1, 6);
      end
    end
  end

  // Compare process: outputs quiet under reset, result on each o_done.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        chk("rst_outs", {63'd0, |{o_busy, o_done, o_qx, o_qy, o_inf,
            o_gfau_start, o_gfau_op, o_gfau_in0, o_gfau_in1}}, 64'd0);
      end else if (o_done) begin
        done_cnt++;
        chk("qx", o_qx, exp_qx);
        chk("qy", o_qy, exp_qy);
        chk("inf", o_inf, exp_inf);
      end
    end
  end

  task automatic launch(input logic [31:0] k);
    ec_mul(k, exp_qx, exp_qy, exp_inf);
    starts = 0;
    @(posedge i_clk);
    #1;
    i_k = k;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int cyc = 0;
    while (done_cnt == d0 && cyc < 30000) begin
      @(posedge i_clk);
      cyc++;
    end
    chk("done_seen", {63'd0, done_cnt != d0}, 64'd1);
    repeat (4) @(posedge i_clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after", o_busy, 0);
    chk("hold_qx", o_qx, exp_qx);
  endtask

  task automatic run(input logic [31:0] k, input int exp_starts);
    int d0 = done_cnt;
    launch(k);
    wait_done(d0);
    if (exp_starts >= 0) chk($sformatf("starts_k%0d", k), starts, exp_starts);
  endtask

  initial begin
    int mx, my, d0, cyc;
    bit mi;
    logic [31:0] rk;

    ec_mul(32'd1, mx, my, mi);
    chk("model_k1", {mx[15:0], my[15:0], 31'd0, mi}, {16'd5, 16'd1, 32'd0});
    ec_mul(32'd2, mx, my, mi);
    chk("model_k2", {mx[15:0], my[15:0], 31'd0, mi}, {16'd6, 16'd3, 32'd0});
    ec_mul(32'd3, mx, my, mi);
    chk("model_k3", {mx[15:0], my[15:0], 31'd0, mi}, {16'd10, 16'd6, 32'd0});
    ec_mul(32'd19, mx, my, mi);
    chk("model_k19", {mx[15:0], my[15:0], 31'd0, mi}, {32'd0, 32'd1});

    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    run(32'd1, 0);
    run(32'd2, 14);
    run(32'd3, 25);
    run(32'd19, -1);
    run(32'd0, 0);
    run(32'd21, -1);

    d0 = done_cnt;
    launch(32'd3);
    repeat (5) @(posedge i_clk);
    #1;
    i_k = 32'd2;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done(d0);
    chk("starts_busy_start", starts, 25);

    d0 = done_cnt;
    launch(32'd7);
    cyc = 0;
    while (starts < 3 && cyc < 5000) begin
      @(posedge i_clk);
      #2;
      cyc++;
    end
    chk("third_op_seen", starts, 3);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    inject_stale = 1'b1;
    repeat (12) @(posedge i_clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", o_busy, 0);
    chk("rst_qx", o_qx, 0);
    run(32'd2, 14);

    for (int n = 0; n < 6; n++) begin
      rk = (n < 4) ? $urandom_range(0, 400) : $urandom;
      run(rk, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
